// File: rtl/tt_um_example_pkg.sv
// Shared types and constants for the three-channel byte packet router.
package tt_um_example_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int NUM_CH     = 3;

    localparam logic [1:0] DEST_INVALID = 2'd3;
    localparam logic [7:0] UIO_OE_MASK  = 8'hF8;

    localparam int UIO_VALID_LSB = 3;
    localparam int UIO_BUSY      = 6;
    localparam int UIO_ERR       = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DROP  = 2'd3
    } state_t;

    // A good packet XORs to zero over header, payload and parity byte.
    function automatic logic parity_bad(input logic [DATA_W-1:0] acc);
        return (acc != {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/tt_um_example_router_fifo.sv
// Show-ahead synchronous FIFO; a write while full is dropped even if a pop happens that cycle.
module router_fifo
    import tt_um_example_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         pop_en,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         do_wr_s;
    logic         do_pop_s;

    assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty    = (wr_ptr_r == rd_ptr_r);
    assign do_wr_s  = wr_en && !full;
    assign do_pop_s = pop_en && !empty;
    assign head     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array, no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/tt_um_example.sv
// Serial byte packet router: header selects one of three FIFOs, parity checked per packet.
module tt_um_example
    import tt_um_example_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_t             state_r;
    logic [1:0]         dest_r;
    logic [DATA_W-1:0]  acc_r;
    logic               err_r;

    logic               byte_valid_s;
    logic [1:0]         hdr_dest_s;
    logic               dest_full_s;
    logic               busy_s;
    logic [NUM_CH-1:0]  wr_en_s;
    logic [NUM_CH-1:0]  pop_en_s;
    logic [NUM_CH-1:0]  full_s;
    logic [NUM_CH-1:0]  empty_s;
    logic [DATA_W-1:0]  head_s [NUM_CH];
    logic [DATA_W-1:0]  rd_byte_s;
    logic               unused_s;

    assign byte_valid_s = ui_in[0];
    assign hdr_dest_s   = ui_in[2:1];
    assign dest_full_s  = (dest_r != DEST_INVALID) ? full_s[dest_r] : 1'b0;
    assign busy_s       = (state_r == LOAD) && byte_valid_s && dest_full_s;
    assign unused_s     = &{1'b0, ena, uio_in[7:3]};

    // Route the incoming byte to the FIFO chosen by the header.
    always_comb begin
        wr_en_s = 3'b000;
        case (state_r)
            IDLE: begin
                if (byte_valid_s && (hdr_dest_s != DEST_INVALID)) begin
                    wr_en_s[hdr_dest_s] = 1'b1;
                end else begin
                    wr_en_s = 3'b000;
                end
            end
            LOAD: begin
                if (byte_valid_s && (dest_r != DEST_INVALID)) begin
                    wr_en_s[dest_r] = 1'b1;
                end else begin
                    wr_en_s = 3'b000;
                end
            end
            default: wr_en_s = 3'b000;
        endcase
    end

    // Packet framing FSM with running XOR parity and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            dest_r  <= 2'd0;
            acc_r   <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (byte_valid_s) begin
                        dest_r  <= hdr_dest_s;
                        err_r   <= 1'b0;
                        acc_r   <= ui_in;
                        state_r <= (hdr_dest_s == DEST_INVALID) ? DROP : LOAD;
                    end
                end
                LOAD: begin
                    if (byte_valid_s) begin
                        if (!dest_full_s) begin
                            acc_r <= acc_r ^ ui_in;
                        end
                    end else begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    err_r   <= parity_bad(acc_r);
                    state_r <= IDLE;
                end
                DROP: begin
                    if (!byte_valid_s) begin
                        err_r   <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Lowest-index enabled channel is shown and popped when non-empty.
    always_comb begin
        pop_en_s  = 3'b000;
        rd_byte_s = 8'h00;
        if (uio_in[0]) begin
            pop_en_s[0] = !empty_s[0];
            rd_byte_s   = empty_s[0] ? 8'h00 : head_s[0];
        end else if (uio_in[1]) begin
            pop_en_s[1] = !empty_s[1];
            rd_byte_s   = empty_s[1] ? 8'h00 : head_s[1];
        end else if (uio_in[2]) begin
            pop_en_s[2] = !empty_s[2];
            rd_byte_s   = empty_s[2] ? 8'h00 : head_s[2];
        end else begin
            pop_en_s  = 3'b000;
            rd_byte_s = 8'h00;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en_s[g]),
            .wr_data (ui_in),
            .pop_en  (pop_en_s[g]),
            .head    (head_s[g]),
            .full    (full_s[g]),
            .empty   (empty_s[g])
        );
    end

    assign uo_out  = rd_byte_s;
    assign uio_out = {err_r, busy_s, ~empty_s, 3'b000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_example.sv
// Directed scoreboard bench for the packet router.
module tb_tt_um_example;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] pkt [$];

    tt_um_example dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic q_push(input int ch, input logic [7:0] b);
        case (ch)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic q_size(input int ch, output int n);
        case (ch)
            0: n = q0.size();
            1: n = q1.size();
            default: n = q2.size();
        endcase
    endtask

    task automatic q_pop(input int ch, output logic [7:0] b);
        case (ch)
            0: b = q0.pop_front();
            1: b = q1.pop_front();
            default: b = q2.pop_front();
        endcase
    endtask

    function automatic logic [7:0] model_valid();
        return {5'd0, q2.size() != 0, q1.size() != 0, q0.size() != 0};
    endfunction

    // Drive the packet in pkt, then the idle cycle and the parity-check cycle.
    task automatic send_pkt(input string tag);
        logic [1:0] d;
        logic [7:0] x;
        int n;
        d = pkt[0][2:1];
        x = 8'h00;
        foreach (pkt[i]) begin
            ui_in = pkt[i];
            x ^= pkt[i];
            if (d != 2'd3) begin
                q_size(int'(d), n);
                if (n < 16) q_push(int'(d), pkt[i]);
            end
            tick;
            if (i == 0) chk({tag, " err_clr"}, {7'd0, uio_out[7]}, 8'h00);
            if (i == 1) chk({tag, " valid_mid"}, {5'd0, uio_out[5:3]}, model_valid());
        end
        ui_in = 8'h00;
        tick;
        tick;
        chk({tag, " err"}, {7'd0, uio_out[7]}, (d == 2'd3) ? 8'h01 : {7'd0, x != 8'h00});
        chk({tag, " valid_end"}, {5'd0, uio_out[5:3]}, model_valid());
    endtask

    task automatic read_drain(input int ch, input string tag);
        int n;
        logic [7:0] e;
        q_size(ch, n);
        uio_in = 8'h00;
        uio_in[ch] = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            q_pop(ch, e);
            chk({tag, " head"}, uo_out, e);
            tick;
        end
        #1;
        chk({tag, " empty_out"}, uo_out, 8'h00);
        chk({tag, " valid_drained"}, {5'd0, uio_out[5:3]}, model_valid());
        uio_in = 8'h00;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic [7:0] x;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        chk("rst uo_out", uo_out, 8'h00);
        chk("rst uio_out", uio_out, 8'h00);
        chk("rst uio_oe", uio_oe, 8'hF8);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        pkt = '{8'h09, 8'hA1, 8'hA3, 8'h0B};
        send_pkt("good");
        read_drain(0, "rd_good");

        pkt = '{8'h09, 8'hA1, 8'hA3, 8'h0D};
        send_pkt("bad");
        read_drain(0, "rd_bad");

        pkt = '{8'h07, 8'h11, 8'h13, 8'h15};
        send_pkt("drop");

        // Fill channel 1 to capacity and hold the 17th byte against back-pressure.
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            b = (i == 0) ? 8'h03 : 8'((i << 4) | 1);
            ui_in = b;
            x ^= b;
            q_push(1, b);
            tick;
        end
        chk("fill valid", {5'd0, uio_out[5:3]}, model_valid());
        b = 8'h5F;
        ui_in = b;
        x ^= b;
        #1;
        chk("full busy", {7'd0, uio_out[6]}, 8'h01);
        tick;
        chk("full busy held", {7'd0, uio_out[6]}, 8'h01);
        uio_in = 8'h02;
        #1;
        q_pop(1, e);
        chk("full pop head", uo_out, e);
        tick;
        uio_in = 8'h00;
        #1;
        chk("busy drop", {7'd0, uio_out[6]}, 8'h00);
        q_push(1, b);
        tick;
        ui_in = 8'h00;
        tick;
        tick;
        chk("full err", {7'd0, uio_out[7]}, {7'd0, x != 8'h00});
        chk("full busy idle", {7'd0, uio_out[6]}, 8'h00);
        read_drain(1, "rd_full");

        // Channels 0 and 2 both pending; read_enb=101 must only pop channel 0.
        pkt = '{8'h09, 8'hA1, 8'hA3, 8'h0B};
        send_pkt("ch0");
        pkt = '{8'h05, 8'hC3, 8'hC5, 8'h03};
        send_pkt("ch2");
        uio_in = 8'h05;
        for (int i = 0; i < 2; i++) begin
            #1;
            q_pop(0, e);
            chk("prio head", uo_out, e);
            tick;
        end
        #1;
        chk("prio valid", {5'd0, uio_out[5:3]}, model_valid());
        uio_in = 8'h00;
        read_drain(2, "rd_ch2");
        read_drain(0, "rd_ch0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
